// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit slot code through eight slots for a 3-to-8
// decoder. Each unmasked slot is held for DWELL cycles. Masked slots are
// skipped, and start/stop control when the scan runs.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | not scanning; code holds the last slot driven, active low
// RUN   | driving slot idx; on the slot's last cycle, advance or stop
// DRAIN | stop seen mid-slot; finish the current slot, then go to IDLE
module scan_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] skip_mask,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       active,
    output logic       slot_done,
    output logic       frame_done
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;

    logic [2:0] nxt_idx;
    logic [2:0] low_idx;
    logic       nxt_ok;
    logic       low_ok;
    logic       last;

    // Returns {found, slot}. The slot is the first unmasked slot in
    // base, base+1, ... taken modulo 8.
    function automatic logic [3:0] find_free(input logic [7:0] mask,
                                             input logic [2:0] base);
        logic [3:0] r;
        logic [2:0] cand;
        r = 4'b0000;
        // Walk the slots in descending order so the nearest one is written last.
        for (int j = 7; j >= 0; j--) begin
            cand = base + 3'(j);
            if (!mask[cand]) begin
                r = {1'b1, cand};
            end
        end
        return r;
    endfunction

    // Slot search from the current slot, slot search from zero, and the
    // last-cycle-of-dwell flag.
    always_comb begin
        {nxt_ok, nxt_idx} = find_free(skip_mask, idx + 3'd1);
        {low_ok, low_idx} = find_free(skip_mask, 3'd0);
        last              = (cnt == CNT_LAST);
    end

    // Outputs are decoded from registers only. The exception is frame_done,
    // which checks the live mask to see whether the scan wraps.
    assign {a, b, c}  = idx;
    assign active     = (state != IDLE);
    assign slot_done  = active && last;
    assign frame_done = slot_done && (!nxt_ok || (nxt_idx <= idx));

    // Sequencer FSM: slot selection, dwell counting and stop handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && low_ok) begin
                        state <= RUN;
                        idx   <= low_idx;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (last) begin
                        cnt <= '0;
                        if (stop || !nxt_ok) begin
                            state <= IDLE;
                        end else begin
                            idx <= nxt_idx;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (stop) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed testbench for scan_sequencer. It runs a DWELL=4 instance and a
// DWELL=1 instance.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stop;
    logic [7:0] skip_mask;
    logic       a, b, c, active, slot_done, frame_done;

    logic       rst1_n, start1, stop1;
    logic [7:0] skip_mask1;
    logic       a1, b1, c1, active1, slot_done1, frame_done1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .skip_mask(skip_mask), .a(a), .b(b), .c(c), .active(active),
        .slot_done(slot_done), .frame_done(frame_done)
    );

    scan_sequencer #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .stop(stop1),
        .skip_mask(skip_mask1), .a(a1), .b(b1), .c(c1), .active(active1),
        .slot_done(slot_done1), .frame_done(frame_done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp0(input string tag, input int code, input bit act,
                        input bit sd, input bit fd);
        chk({tag, " code"}, {5'd0, a, b, c}, 8'(code));
        chk({tag, " active"}, {7'd0, active}, {7'd0, act});
        chk({tag, " slot_done"}, {7'd0, slot_done}, {7'd0, sd});
        chk({tag, " frame_done"}, {7'd0, frame_done}, {7'd0, fd});
    endtask

    task automatic exp1(input string tag, input int code, input bit act,
                        input bit sd, input bit fd);
        chk({tag, " code"}, {5'd0, a1, b1, c1}, 8'(code));
        chk({tag, " active"}, {7'd0, active1}, {7'd0, act});
        chk({tag, " slot_done"}, {7'd0, slot_done1}, {7'd0, sd});
        chk({tag, " frame_done"}, {7'd0, frame_done1}, {7'd0, fd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; skip_mask = 8'h00;
        rst1_n = 1'b1; start1 = 1'b0; stop1 = 1'b0; skip_mask1 = 8'h00;
        #1;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        #1;
        exp0("reset", 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp0("idle after reset", 0, 0, 0, 0);

        // Test 1: full frame with no mask, DWELL=4.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (cyc > 1) tick();
            exp0($sformatf("t1 c%0d", cyc), ((cyc - 1) / 4) % 8, 1,
                 (cyc % 4) == 0, cyc == 32);
        end

        // Test 3: stop pulse at slot 3, cnt=1. The slot completes, then IDLE.
        for (int cyc = 34; cyc <= 48; cyc++) begin
            tick();
            stop = (cyc == 46);
            exp0($sformatf("t3 c%0d", cyc), ((cyc - 1) / 4) % 8, 1,
                 (cyc % 4) == 0, 0);
        end
        tick();
        exp0("t3 idle", 3, 0, 0, 0);
        tick();
        exp0("t3 idle hold", 3, 0, 0, 0);

        // Test 2: mask AA with start held high.
        skip_mask = 8'hAA;
        start     = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (cyc > 1) tick();
            exp0($sformatf("t2 c%0d", cyc), (2 * ((cyc - 1) / 4)) % 8, 1,
                 (cyc % 4) == 0,
                 ((cyc % 4) == 0) && (((2 * ((cyc - 1) / 4)) % 8) == 6));
        end
        stop = 1'b1;
        tick();
        exp0("t2 stop at last", 2, 0, 0, 0);
        // Both start and stop are high in IDLE, so stop wins.
        for (int i = 0; i < 3; i++) begin
            tick();
            exp0($sformatf("start+stop idle %0d", i), 2, 0, 0, 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Test 4: all slots masked, then a single unmasked slot.
        rst_n = 1'b0;
        #1;
        exp0("async reset", 0, 0, 0, 0);
        tick();
        rst_n     = 1'b1;
        skip_mask = 8'hFF;
        start     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp0($sformatf("t4 all masked %0d", i), 0, 0, 0, 0);
        end
        skip_mask = 8'h7F;
        tick();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc > 1) tick();
            exp0($sformatf("t4 single c%0d", cyc), 7, 1,
                 (cyc % 4) == 0, (cyc % 4) == 0);
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        exp0("t4 stopped", 7, 0, 0, 0);
        stop = 1'b0;

        // Test 5: mask changes mid-slot and takes effect only at the next slot.
        skip_mask = 8'h00;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc > 1) tick();
            if (cyc == 10) skip_mask = 8'hFE;
            if (cyc <= 12)
                exp0($sformatf("t5 c%0d", cyc), (cyc - 1) / 4, 1,
                     (cyc % 4) == 0, (cyc == 12));
            else
                exp0($sformatf("t5 c%0d", cyc), 0, 1,
                     (cyc % 4) == 0, (cyc % 4) == 0);
        end
        stop = 1'b1;
        tick();
        exp0("t5 stopped", 0, 0, 0, 0);
        stop = 1'b0;

        // Test 6: DWELL=1 instance, then an asynchronous reset in slot 5.
        rst1_n = 1'b1;
        tick();
        exp1("d1 idle", 0, 0, 0, 0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc > 1) tick();
            exp1($sformatf("d1 c%0d", cyc), cyc - 1, 1, 1, 0);
        end
        #2;
        rst1_n = 1'b0;
        #1;
        exp1("d1 async reset", 0, 0, 0, 0);
        tick();
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp1($sformatf("d1 post reset %0d", i), 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
